delay_suite_rmw_burst_gen: RTL and testbench

//  Burst address sequencer directly upstream of the 8-entry read-cond-masked-write memory stage.

---
 rtl/delay_suite_rmw_burst_gen.sv | 93 +++++++++
 tb/tb_delay_suite_rmw_burst_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_suite_rmw_burst_gen.sv
// Burst address sequencer feeding the 8-entry masked-write memory stage.
// Define BURST_WRAP_EN to wrap bursts inside the aligned 2^DEPTH_LOG2 window; default is linear.
module delay_suite_rmw_burst_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic [ADDR_W-1:0] io_cmd_addr,
    input  logic [LEN_W-1:0]  io_cmd_len,
    input  logic              io_stall,
    output logic              io_enable,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_busy,
    output logic              io_done
);

    localparam int unsigned BW = LEN_W + 1;
    localparam int unsigned HW = ADDR_W - DEPTH_LOG2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     beats_q;
    logic              done_q;

    logic [DEPTH_LOG2-1:0] low_inc;
    logic                  low_carry;
    logic [ADDR_W-1:0]     addr_next;
    logic                  last_beat;
    logic                  advance;

    // Increment split at the window boundary; linear mode just propagates the carry upward.
    always_comb begin
        low_inc   = addr_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
        low_carry = &addr_q[DEPTH_LOG2-1:0];
`ifdef BURST_WRAP_EN
        addr_next = {addr_q[ADDR_W-1:DEPTH_LOG2], low_inc};
`else
        addr_next = {addr_q[ADDR_W-1:DEPTH_LOG2] + HW'(low_carry), low_inc};
`endif
    end

    always_comb begin
        io_cmd_ready = (state_q == IDLE);
        io_busy      = (state_q == RUN);
        advance      = (state_q == RUN) && !io_stall;
        io_enable    = advance;
        io_addr      = addr_q;
        io_done      = done_q;
        last_beat    = (beats_q == BW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (io_cmd_valid) begin
                    addr_q  <= io_cmd_addr;
                    beats_q <= {1'b0, io_cmd_len} + BW'(1);
                    state_q <= RUN;
                end
            end else if (advance) begin
                // The final beat leaves addr_q alone so IDLE shows the last issued address.
                if (last_beat) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    beats_q <= beats_q - BW'(1);
                    addr_q  <= addr_next;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_done_pulse : assert property (@(posedge clk) disable iff (!reset) io_done |=> !io_done);
    a_enable_busy : assert property (@(posedge clk) disable iff (!reset) io_enable |-> io_busy);
    a_ready_idle : assert property (@(posedge clk) disable iff (!reset) io_cmd_ready == !io_busy);
    a_beats_live : assert property (@(posedge clk) disable iff (!reset) io_busy |-> beats_q != '0);
`endif

endmodule

// File: tb/tb_delay_suite_rmw_burst_gen.sv
// Self-checking bench for delay_suite_rmw_burst_gen: directed cases plus randomized traffic
// compared every cycle against a queue-based burst model. Honors BURST_WRAP_EN.
module tb_delay_suite_rmw_burst_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_ready;
    logic [31:0] io_cmd_addr = '0;
    logic [3:0]  io_cmd_len = '0;
    logic        io_stall = 1'b0;
    logic        io_enable;
    logic [31:0] io_addr;
    logic        io_busy;
    logic        io_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_suite_rmw_burst_gen #(
        .ADDR_W    (32),
        .LEN_W     (4),
        .DEPTH_LOG2(3)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .io_cmd_valid(io_cmd_valid),
        .io_cmd_ready(io_cmd_ready),
        .io_cmd_addr (io_cmd_addr),
        .io_cmd_len  (io_cmd_len),
        .io_stall    (io_stall),
        .io_enable   (io_enable),
        .io_addr     (io_addr),
        .io_busy     (io_busy),
        .io_done     (io_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_a(input logic [31:0] a);
`ifdef BURST_WRAP_EN
        return (a & ~32'h7) | ((a + 32'd1) & 32'h7);
`else
        return a + 32'd1;
`endif
    endfunction

    // Reference model: a burst is the list of its addresses; each unstalled cycle consumes one.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    logic        m_done;

    initial begin
        logic        m_busy;
        logic [31:0] a;
        m_last = '0;
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("m_rst_ready", {31'b0, io_cmd_ready}, 32'd1);
                chk("m_rst_busy", {31'b0, io_busy}, 32'd0);
                chk("m_rst_enable", {31'b0, io_enable}, 32'd0);
                chk("m_rst_done", {31'b0, io_done}, 32'd0);
                chk("m_rst_addr", io_addr, 32'd0);
            end else begin
                m_busy = (mq.size() != 0);
                chk("m_ready", {31'b0, io_cmd_ready}, {31'b0, !m_busy});
                chk("m_busy", {31'b0, io_busy}, {31'b0, m_busy});
                chk("m_enable", {31'b0, io_enable}, {31'b0, m_busy && !io_stall});
                chk("m_addr", io_addr, m_busy ? mq[0] : m_last);
                chk("m_done", {31'b0, io_done}, {31'b0, m_done});
            end
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                m_last = '0;
                m_done = 1'b0;
            end else begin
                m_busy = (mq.size() != 0);
                m_done = 1'b0;
                if (m_busy) begin
                    if (!io_stall) begin
                        m_last = mq.pop_front();
                        if (mq.size() == 0) m_done = 1'b1;
                    end
                end else if (io_cmd_valid) begin
                    a = io_cmd_addr;
                    for (int i = 0; i <= int'(io_cmd_len); i++) begin
                        mq.push_back(a);
                        a = next_a(a);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e2 [4];
        logic        en3 [5];
        logic        st3 [5];
        logic [31:0] ad3 [5];
`ifdef BURST_WRAP_EN
        e2 = '{32'h15, 32'h16, 32'h17, 32'h10};
        chk("model_next_pin", next_a(32'h17), 32'h10);
`else
        e2 = '{32'h15, 32'h16, 32'h17, 32'h18};
        chk("model_next_pin", next_a(32'h17), 32'h18);
`endif
        en3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        st3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ad3 = '{32'h2, 32'h3, 32'h3, 32'h3, 32'h4};

        // 1: reset held with a command pending
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h55;
        repeat (3) begin
            @(negedge clk);
            chk("t1_ready", {31'b0, io_cmd_ready}, 32'd1);
            chk("t1_enable", {31'b0, io_enable}, 32'd0);
            chk("t1_busy", {31'b0, io_busy}, 32'd0);
            chk("t1_done", {31'b0, io_done}, 32'd0);
            chk("t1_addr", io_addr, 32'd0);
        end
        step();
        reset = 1'b1;
        io_cmd_valid = 1'b0;
        @(negedge clk);
        step();

        // 2: four-beat burst, no stall
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h15;
        io_cmd_len   = 4'd3;
        @(negedge clk);
        chk("t2_ready", {31'b0, io_cmd_ready}, 32'd1);
        step();
        io_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_enable", {31'b0, io_enable}, 32'd1);
            chk("t2_addr", io_addr, e2[i]);
            chk("t2_done_low", {31'b0, io_done}, 32'd0);
            step();
        end
        @(negedge clk);
        chk("t2_done", {31'b0, io_done}, 32'd1);
        chk("t2_enable_off", {31'b0, io_enable}, 32'd0);
        step();
        @(negedge clk);
        chk("t2_done_clr", {31'b0, io_done}, 32'd0);
        step();

        // 3: stall on the second beat for two cycles
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h2;
        io_cmd_len   = 4'd2;
        step();
        io_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            io_stall = st3[i];
            @(negedge clk);
            chk("t3_enable", {31'b0, io_enable}, {31'b0, en3[i]});
            chk("t3_addr", io_addr, ad3[i]);
            chk("t3_done_low", {31'b0, io_done}, 32'd0);
            step();
        end
        io_stall = 1'b0;
        @(negedge clk);
        chk("t3_done", {31'b0, io_done}, 32'd1);
        step();
        @(negedge clk);
        chk("t3_done_once", {31'b0, io_done}, 32'd0);
        step();

        // 4: back-to-back commands, second accepted in the done cycle
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h0;
        io_cmd_len   = 4'd0;
        step();
        io_cmd_addr  = 32'h4;
        io_cmd_len   = 4'd1;
        @(negedge clk);
        chk("t4_en0", {31'b0, io_enable}, 32'd1);
        chk("t4_addr0", io_addr, 32'h0);
        chk("t4_ready_run", {31'b0, io_cmd_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("t4_done1", {31'b0, io_done}, 32'd1);
        chk("t4_busy_gap", {31'b0, io_busy}, 32'd0);
        chk("t4_ready_gap", {31'b0, io_cmd_ready}, 32'd1);
        step();
        io_cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_addr4", io_addr, 32'h4);
        chk("t4_busy2", {31'b0, io_busy}, 32'd1);
        step();
        @(negedge clk);
        chk("t4_addr5", io_addr, 32'h5);
        step();
        @(negedge clk);
        chk("t4_done2", {31'b0, io_done}, 32'd1);
        step();

        // 5: new command presented while a burst runs
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h100;
        io_cmd_len   = 4'd3;
        step();
        io_cmd_addr  = 32'h200;
        io_cmd_len   = 4'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_ready", {31'b0, io_cmd_ready}, 32'd0);
            chk("t5_addr", io_addr, 32'h100 + 32'(i));
            step();
        end
        io_cmd_valid = 1'b0;
        repeat (10) step();

        // 6: top-of-space wrap, then reset in the middle of a burst
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'hFFFF_FFFF;
        io_cmd_len   = 4'd1;
        step();
        io_cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_addr_top", io_addr, 32'hFFFF_FFFF);
        step();
        @(negedge clk);
`ifdef BURST_WRAP_EN
        chk("t6_addr_wrap", io_addr, 32'hFFFF_FFF8);
`else
        chk("t6_addr_wrap", io_addr, 32'h0000_0000);
`endif
        step();
        @(negedge clk);
        chk("t6_done", {31'b0, io_done}, 32'd1);
        step();
        io_cmd_valid = 1'b1;
        io_cmd_addr  = 32'h40;
        io_cmd_len   = 4'd5;
        step();
        io_cmd_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", {31'b0, io_busy}, 32'd0);
        chk("t6_rst_addr", io_addr, 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_done", {31'b0, io_done}, 32'd0);
            chk("t6_idle", {31'b0, io_busy}, 32'd0);
            step();
        end

        // randomized traffic, checked by the model every cycle
        repeat (600) begin
            io_cmd_valid = ($urandom_range(0, 2) != 0);
            io_cmd_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            io_cmd_len   = 4'($urandom_range(0, 15));
            io_stall     = ($urandom_range(0, 2) == 0);
            reset        = ($urandom_range(0, 149) != 0);
            step();
        end
        reset = 1'b1;
        io_cmd_valid = 1'b0;
        io_stall = 1'b0;
        repeat (20) step();

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
